// File: rtl/axi_burst_master_if.sv
// rtl/axi_burst_master_if.sv - AXI4 master/slave channel bundle for axi_burst_master
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master for cache line refill/writeback
module axi_burst_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2:0]              req_size_i,
    input  logic [7:0]              req_len_i,
    input  logic                    wdata_valid_i,
    output logic                    wdata_ready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    output logic                    rdata_valid_o,
    input  logic                    rdata_ready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rdata_last_o,
    output logic                    done_o,
    output logic [1:0]              done_resp_o,
    axi_burst_master_if.master      axi
);
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              size_q;
    logic [7:0]              len_q;
    logic [BW-1:0]           beat_cnt_q;
    logic                    aw_done_q, w_done_q, overrun_q;
    logic [1:0]              resp_acc_q, done_resp_q;
    logic                    req_ready_q, aw_valid_q, ar_valid_q, b_ready_q, done_q;

    logic                    at_last, in_write, in_rdata;
    logic                    w_valid, w_hs, aw_hs, r_ready, r_hs;
    logic [1:0]              rresp_d;

    // Ordering DECERR > SLVERR > OKAY matches the numeric encoding once EXOKAY folds to OKAY.
    function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
        logic [1:0] r;
        r = (resp == RESP_EXOKAY) ? RESP_OKAY : resp;
        return (r > acc) ? r : acc;
    endfunction

    assign at_last  = (beat_cnt_q == len_q[BW-1:0]);
    assign in_write = (state_q == S_WRITE);
    assign in_rdata = (state_q == S_RDATA);
    assign w_valid  = in_write & ~w_done_q & wdata_valid_i;
    assign w_hs     = w_valid & axi.w_ready;
    assign aw_hs    = aw_valid_q & axi.aw_ready;
    // Once the expected length is exceeded the slave's surplus beats are swallowed here.
    assign r_ready  = in_rdata & (overrun_q | rdata_ready_i);
    assign r_hs     = axi.r_valid & r_ready;
    assign rresp_d  = merge_resp(resp_acc_q, axi.r_resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            overrun_q   <= 1'b0;
            resp_acc_q  <= RESP_OKAY;
            done_resp_q <= RESP_OKAY;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: if (req_valid_i) begin
                    addr_q      <= req_addr_i;
                    size_q      <= req_size_i;
                    len_q       <= req_len_i;
                    beat_cnt_q  <= '0;
                    aw_done_q   <= 1'b0;
                    w_done_q    <= 1'b0;
                    overrun_q   <= 1'b0;
                    resp_acc_q  <= RESP_OKAY;
                    req_ready_q <= 1'b0;
                    if (req_write_i) begin
                        state_q    <= S_WRITE;
                        aw_valid_q <= 1'b1;
                    end else begin
                        state_q    <= S_RADDR;
                        ar_valid_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (aw_hs) begin
                        aw_done_q  <= 1'b1;
                        aw_valid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (at_last) w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_hs) & (w_done_q | (w_hs & at_last))) begin
                        state_q   <= S_WRESP;
                        b_ready_q <= 1'b1;
                    end
                end
                S_WRESP: if (axi.b_valid) begin
                    b_ready_q   <= 1'b0;
                    done_q      <= 1'b1;
                    done_resp_q <= merge_resp(RESP_OKAY, axi.b_resp);
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_RADDR: if (axi.ar_ready) begin
                    ar_valid_q <= 1'b0;
                    state_q    <= S_RDATA;
                end
                S_RDATA: if (r_hs) begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                    resp_acc_q <= rresp_d;
                    if (axi.r_last) begin
                        done_q      <= 1'b1;
                        done_resp_q <= (overrun_q | ~at_last) ? merge_resp(rresp_d, RESP_SLVERR)
                                                              : rresp_d;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (at_last) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = w_hs;
    assign rdata_valid_o = in_rdata & axi.r_valid & ~overrun_q;
    assign rdata_o       = axi.r_data;
    assign rdata_last_o  = in_rdata & axi.r_valid & ~overrun_q & at_last;
    assign done_o        = done_q;
    assign done_resp_o   = done_resp_q;

    assign axi.aw_id     = '0;
    assign axi.aw_addr   = addr_q;
    assign axi.aw_len    = len_q;
    assign axi.aw_size   = size_q;
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = '0;
    assign axi.aw_prot   = '0;
    assign axi.aw_qos    = '0;
    assign axi.aw_region = '0;
    assign axi.aw_user   = '0;
    assign axi.aw_valid  = aw_valid_q;

    assign axi.w_data    = wdata_i;
    assign axi.w_strb    = wstrb_i;
    assign axi.w_last    = at_last;
    assign axi.w_user    = '0;
    assign axi.w_valid   = w_valid;
    assign axi.b_ready   = b_ready_q;

    assign axi.ar_id     = '0;
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = len_q;
    assign axi.ar_size   = size_q;
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = '0;
    assign axi.ar_prot   = '0;
    assign axi.ar_qos    = '0;
    assign axi.ar_region = '0;
    assign axi.ar_user   = '0;
    assign axi.ar_valid  = ar_valid_q;
    assign axi.r_ready   = r_ready;

    logic unused_ok;
    assign unused_ok = ^{axi.b_id, axi.b_user, axi.r_id, axi.r_user};
endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - scoreboard bench for axi_burst_master with a randomized AXI slave
module tb_axi_burst_master;
    localparam int DW = 64, AW = 64, IW = 4, UW = 1, MB = 8;

    typedef struct packed { logic [63:0] addr; logic [7:0] len; logic [2:0] size; } addr_t;
    typedef struct packed { logic [DW-1:0] data; logic last; } rbeat_t;
    typedef struct packed { logic [DW-1:0] data; logic [7:0] strb; logic last; } wbeat_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [7:0]    req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic          rdata_valid, rdata_ready, rdata_last;
    logic [DW-1:0] rdata;
    logic          done;
    logic [1:0]    done_resp;

    axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW)) axi ();

    axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .USER_WIDTH(UW),
                       .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata), .wstrb_i(wstrb),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .rdata_last_o(rdata_last), .done_o(done), .done_resp_o(done_resp), .axi(axi)
    );

    int checks = 0, errors = 0;
    int cyc = 0, term_cyc = -100;
    always @(posedge clk) cyc <= cyc + 1;

    addr_t      exp_ar[$], exp_aw[$];
    rbeat_t     exp_r[$];
    wbeat_t     exp_w[$];
    logic [1:0] exp_done[$];

    logic [DW-1:0] rd_data[16];
    logic [1:0]    rd_resp[16];
    logic [DW-1:0] wr_data[16];
    logic [7:0]    wr_strb[16];
    int ready_mode = 0, gap_max = 0, aw_delay = 0, wgap_max = 0;
    bit ar_zero_wait = 1, w_ready_rand = 0, rd_busy = 0, wr_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s: actual=%s required=%s", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    addr_t mon_a; rbeat_t mon_r; wbeat_t mon_w; logic [1:0] mon_d;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (axi.ar_valid && axi.ar_ready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected", "handshake", "none");
                else begin
                    mon_a = exp_ar.pop_front();
                    chk("ar_addr", axi.ar_addr, mon_a.addr);
                    chk("ar_len", axi.ar_len, mon_a.len);
                    chk("ar_size", axi.ar_size, mon_a.size);
                    chk("ar_burst", axi.ar_burst, 2'b01);
                    chk("ar_id", axi.ar_id, '0);
                end
            end
            if (axi.aw_valid && axi.aw_ready) begin
                if (exp_aw.size() == 0) fail("aw_unexpected", "handshake", "none");
                else begin
                    mon_a = exp_aw.pop_front();
                    chk("aw_addr", axi.aw_addr, mon_a.addr);
                    chk("aw_len", axi.aw_len, mon_a.len);
                    chk("aw_size", axi.aw_size, mon_a.size);
                    chk("aw_burst", axi.aw_burst, 2'b01);
                end
            end
            if (axi.w_valid && axi.w_ready) begin
                if (exp_w.size() == 0) fail("w_unexpected", "handshake", "none");
                else begin
                    mon_w = exp_w.pop_front();
                    chk("w_data", axi.w_data, mon_w.data);
                    chk("w_strb", axi.w_strb, mon_w.strb);
                    chk("w_last", axi.w_last, mon_w.last);
                    chk("wdata_ready", wdata_ready, 1'b1);
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_r.size() == 0) fail("rdata_unexpected", "beat", "none");
                else begin
                    mon_r = exp_r.pop_front();
                    chk("rdata", rdata, mon_r.data);
                    chk("rdata_last", rdata_last, mon_r.last);
                end
            end
            if ((axi.r_valid && axi.r_ready && axi.r_last) || (axi.b_valid && axi.b_ready))
                term_cyc = cyc;
            if (done) begin
                if (exp_done.size() == 0) fail("done_unexpected", "pulse", "none");
                else begin
                    mon_d = exp_done.pop_front();
                    chk("done_resp", done_resp, mon_d);
                    chk("done_latency", cyc, term_cyc + 1);
                    chk("ready_at_done", req_ready, 1'b1);
                end
            end
        end
    end

    task automatic issue_req(input logic wr, input logic [63:0] addr, input logic [7:0] len);
        req_write = wr; req_addr = addr; req_size = 3'd3; req_len = len; req_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        fail("req_hs", "timeout", "handshake");
    endtask

    // which: 1=AW, 2=R, 3=requester W, 4=B
    task automatic wait_hs(input int which, input string name);
        logic ok;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            case (which)
                1: ok = axi.aw_valid && axi.aw_ready;
                2: ok = axi.r_ready;
                3: ok = wdata_ready;
                default: ok = axi.b_ready;
            endcase
            @(posedge clk); #1;
            if (ok) return;
        end
        fail(name, "timeout", "handshake");
    endtask

    task automatic wait_done();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) return;
        end
        fail("done_wait", "timeout", "done pulse");
    endtask

    task automatic slave_ar();
        for (int t = 0; t < 200; t++) begin
            axi.ar_ready = ar_zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (axi.ar_valid && axi.ar_ready) begin
                @(posedge clk); #1;
                axi.ar_ready = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        fail("ar_hs", "timeout", "handshake");
    endtask

    task automatic send_r(input logic [DW-1:0] d, input logic [1:0] rr, input logic l);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        axi.r_valid = 1'b1; axi.r_data = d; axi.r_resp = rr; axi.r_last = l;
        wait_hs(2, "r_hs");
        axi.r_valid = 1'b0; axi.r_last = 1'b0;
    endtask

    // Reference: the requester sees min(len+1, sent) beats; response is the worst RRESP
    // seen, raised to SLVERR whenever the slave's beat count differs from len+1.
    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input int nbeats);
        addr_t a; rbeat_t b; logic [1:0] r; int deliver;
        a.addr = addr; a.len = len; a.size = 3'd3;
        exp_ar.push_back(a);
        deliver = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
        for (int i = 0; i < deliver; i++) begin
            b.data = rd_data[i]; b.last = (i == int'(len));
            exp_r.push_back(b);
        end
        r = 2'b00;
        for (int i = 0; i < nbeats; i++) if (rd_resp[i] > r) r = rd_resp[i];
        if (nbeats != int'(len) + 1 && r < 2'b10) r = 2'b10;
        exp_done.push_back(r);
        issue_req(1'b0, addr, len);
        rd_busy = 1'b1;
        fork
            begin
                while (rd_busy) begin
                    case (ready_mode)
                        0: rdata_ready = 1'b1;
                        1: rdata_ready = ~rdata_ready;
                        default: rdata_ready = ($urandom_range(0, 3) != 0);
                    endcase
                    @(posedge clk); #1;
                end
            end
            begin
                slave_ar();
                for (int i = 0; i < nbeats; i++) send_r(rd_data[i], rd_resp[i], i == nbeats - 1);
                wait_done();
                rd_busy = 1'b0;
            end
        join
        rdata_ready = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] bresp);
        addr_t a; wbeat_t w;
        a.addr = addr; a.len = len; a.size = 3'd3;
        exp_aw.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = wr_data[i]; w.strb = wr_strb[i]; w.last = (i == int'(len));
            exp_w.push_back(w);
        end
        exp_done.push_back(bresp);
        issue_req(1'b1, addr, len);
        wr_busy = 1'b1;
        fork
            begin
                repeat (aw_delay) begin @(posedge clk); #1; end
                axi.aw_ready = 1'b1;
                wait_hs(1, "aw_hs");
                axi.aw_ready = 1'b0;
            end
            begin
                for (int i = 0; i <= int'(len); i++) begin
                    repeat ((wgap_max > 0) ? int'($urandom_range(0, wgap_max)) : 0) begin
                        @(posedge clk); #1;
                    end
                    wdata_valid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i];
                    wait_hs(3, "w_hs");
                    wdata_valid = 1'b0;
                end
                wr_busy = 1'b0;
            end
            begin
                while (wr_busy) begin
                    axi.w_ready = w_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(posedge clk); #1;
                end
                axi.w_ready = 1'b0;
            end
        join
        axi.b_valid = 1'b1; axi.b_resp = bresp;
        wait_hs(4, "b_hs");
        axi.b_valid = 1'b0;
        wait_done();
    endtask

    function automatic logic [1:0] rand_resp();
        int k;
        k = $urandom_range(0, 5);
        return (k == 4) ? 2'b10 : (k == 5) ? 2'b11 : 2'b00;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < 16; i++) begin
            rd_data[i] = {$urandom, $urandom};
            rd_resp[i] = (i < n) ? rand_resp() : 2'b00;
            wr_data[i] = {$urandom, $urandom};
            wr_strb[i] = 8'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 0; req_write = 0; req_addr = '0; req_size = '0; req_len = '0;
        wdata_valid = 0; wdata = '0; wstrb = '0; rdata_ready = 0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.b_valid = 0; axi.b_resp = 0; axi.b_id = '0; axi.b_user = '0;
        axi.r_valid = 0; axi.r_data = '0; axi.r_resp = 0; axi.r_last = 0;
        axi.r_id = '0; axi.r_user = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, rdata_valid}, '0);
        chk("rst_done_last", {done, rdata_last, done_resp}, '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait 8-beat refill
        fill_random(0);
        ar_zero_wait = 1; gap_max = 0; ready_mode = 0;
        do_read(64'h8000_0040, 8'd7, 8);
        // Write whose data leads AWREADY by two cycles
        aw_delay = 2; wgap_max = 0; w_ready_rand = 0;
        do_write(64'h8000_1000, 8'd3, 2'b00);
        // Requester backpressure toggling every cycle
        fill_random(0);
        ready_mode = 1;
        do_read(64'h0000_2000, 8'd3, 4);
        // Response merge across beats
        fill_random(0);
        ready_mode = 0;
        rd_resp[1] = 2'b10; rd_resp[2] = 2'b11;
        do_read(64'h0000_3000, 8'd3, 4);
        // Early RLAST, then overrun drain
        fill_random(0);
        do_read(64'h0000_4000, 8'd3, 2);
        fill_random(0);
        do_read(64'h0000_5000, 8'd1, 3);

        // Reset while the second write beat is on offer
        fill_random(0);
        mon_w.data = wr_data[0]; mon_w.strb = wr_strb[0]; mon_w.last = 1'b0;
        exp_w.push_back(mon_w);
        issue_req(1'b1, 64'h0000_6000, 8'd3);
        axi.aw_ready = 1'b0; axi.w_ready = 1'b1;
        wdata_valid = 1'b1; wdata = wr_data[0]; wstrb = wr_strb[0];
        wait_hs(3, "w_hs_rst");
        wdata = wr_data[1]; wstrb = wr_strb[1];
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready,
                               rdata_valid, wdata_ready, done}, '0);
        wdata_valid = 1'b0; axi.w_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random(4);
        do_read(64'h0000_7000, 8'd3, 4);

        // Randomized mix
        for (int n = 0; n < 24; n++) begin
            logic [7:0] len;
            int sel, nb;
            len = 8'($urandom_range(0, MB - 1));
            ar_zero_wait = 1'($urandom_range(0, 1));
            gap_max = $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 2);
            aw_delay = $urandom_range(0, 4);
            wgap_max = $urandom_range(0, 2);
            w_ready_rand = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                fill_random(0);
                do_write({$urandom, $urandom} & ~64'h7, len, rand_resp());
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 7 || len == 0) nb = int'(len) + 1;
                else if (sel < 9) nb = $urandom_range(1, int'(len));
                else nb = int'(len) + 1 + $urandom_range(1, 2);
                fill_random((nb < int'(len) + 1) ? nb : int'(len) + 1);
                do_read({$urandom, $urandom} & ~64'h7, len, nb);
            end
        end

        repeat (3) @(posedge clk);
        chk("left_r", exp_r.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("left_addr", exp_ar.size() + exp_aw.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
